serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell and a carry flop, LSB first,
// wrapped in a start/busy/done handshake. {cout,s} = a + b + cin.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for start
// RUN    | one operand bit per clock through the adder
// DONE   | one-cycle completion pulse; may accept again
module serial_adder #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         cout
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  p_q, p_d;
    logic          c_q, c_d;
    logic [KW-1:0] k_q, k_d;
    logic [N-1:0]  s_q, s_d;
    logic          cout_q, cout_d;

    logic          sum_bit;
    logic          carry_nxt;
    logic [N:0]    p_ext;
    logic [N-1:0]  p_shift;

    assign sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
    assign carry_nxt = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & c_q);
    // Sum bit enters at the MSB; written as a wide slice so N=1 stays legal.
    assign p_ext     = {sum_bit, p_q};
    assign p_shift   = p_ext[N:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            c_q     <= 1'b0;
            k_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            c_q     <= c_d;
            k_q     <= k_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        c_d     = c_q;
        k_d     = k_q;
        s_d     = s_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    k_d     = '0;
                    p_d     = '0;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d = a_q >> 1;
                b_d = b_q >> 1;
                c_d = carry_nxt;
                p_d = p_shift;
                k_d = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                    s_d     = p_shift;
                    cout_d  = carry_nxt;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder at N=4, N=1 and N=8,
// checked against plain integer addition of the captured operands.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       st [3];
    logic [7:0] ai [3];
    logic [7:0] bi [3];
    logic       ci [3];

    logic       busy4, done4, cout4;
    logic [3:0] s4;
    logic       busy1, done1, cout1;
    logic [0:0] s1;
    logic       busy8, done8, cout8;
    logic [7:0] s8;

    int vectors;
    int miscompares;
    int wid [3] = '{4, 1, 8};
    int prev [3];

    serial_adder #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(st[0]), .a(ai[0][3:0]), .b(bi[0][3:0]), .cin(ci[0]),
        .busy(busy4), .done(done4), .s(s4), .cout(cout4)
    );
    serial_adder #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .a(ai[1][0:0]), .b(bi[1][0:0]), .cin(ci[1]),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1)
    );
    serial_adder #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(st[2]), .a(ai[2]), .b(bi[2]), .cin(ci[2]),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic rd(input int sel, output logic bz, output logic dn, output int res);
        case (sel)
            0:       begin bz = busy4; dn = done4; res = int'({cout4, s4}); end
            1:       begin bz = busy1; dn = done1; res = int'({cout1, s1}); end
            default: begin bz = busy8; dn = done8; res = int'({cout8, s8}); end
        endcase
    endtask

    function automatic int ref_sum(input int sel, input logic [7:0] av, input logic [7:0] bv,
                                   input logic cv);
        int m;
        m = (1 << wid[sel]) - 1;
        return (int'(av) & m) + (int'(bv) & m) + int'(cv);
    endfunction

    // One full transaction: pulse start, scramble inputs, time busy, check result.
    task automatic op(input int sel, input logic [7:0] av, input logic [7:0] bv, input logic cv);
        logic bz, dn;
        int   res, n, exp;
        exp = ref_sum(sel, av, bv, cv);
        @(negedge clk);
        st[sel] = 1'b1; ai[sel] = av; bi[sel] = bv; ci[sel] = cv;
        @(negedge clk);
        st[sel] = 1'b0;
        ai[sel] = 8'($urandom); bi[sel] = 8'($urandom); ci[sel] = 1'($urandom);
        n = 0;
        rd(sel, bz, dn, res);
        while (bz && n < 40) begin
            check("hold_s_in_run", res, prev[sel]);
            check("no_done_in_run", int'(dn), 0);
            n++;
            @(negedge clk);
            rd(sel, bz, dn, res);
        end
        check("busy_len", n, wid[sel]);
        check("done_pulse", int'(dn), 1);
        check("sum", res, exp);
        prev[sel] = exp;
        @(negedge clk);
        rd(sel, bz, dn, res);
        check("done_one_cycle", int'(dn), 0);
        check("hold_after_done", res, prev[sel]);
    endtask

    initial begin
        logic bz, dn;
        int   res, n, dcount, at_done;
        logic [8:0] v;

        vectors = 0; miscompares = 0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0; ai[i] = '0; bi[i] = '0; ci[i] = 1'b0; prev[i] = 0;
        end
        repeat (3) @(negedge clk);
        st[0] = 1'b1;                  // reset must win over start
        @(negedge clk);
        st[0] = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd(i, bz, dn, res);
            check("rst_busy", int'(bz), 0);
            check("rst_done", int'(dn), 0);
            check("rst_sum", res, 0);
        end

        op(0, 8'h5, 8'h3, 1'b0);
        op(0, 8'hF, 8'h1, 1'b0);
        op(0, 8'hF, 8'hF, 1'b1);

        // start during RUN is ignored
        @(negedge clk);
        st[0] = 1'b1; ai[0] = 8'h2; bi[0] = 8'h2; ci[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b1; ai[0] = 8'h9; bi[0] = 8'h9;
        @(negedge clk);
        st[0] = 1'b0; ai[0] = 8'h5; bi[0] = 8'h6;
        dcount = 0; at_done = -1;
        for (int i = 0; i < 8; i++) begin
            rd(0, bz, dn, res);
            if (dn) begin dcount++; at_done = res; end
            @(negedge clk);
        end
        check("ignore_start_dones", dcount, 1);
        check("ignore_start_sum", at_done, 4);
        prev[0] = 4;

        // back-to-back with start held high
        st[0] = 1'b1; ai[0] = 8'h1; bi[0] = 8'h1; ci[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            rd(0, bz, dn, res);
            n++;
        end while (!dn && n < 20);
        check("b2b_first_done", int'(dn), 1);
        check("b2b_first_sum", res, 2);
        ai[0] = 8'h7; bi[0] = 8'h8;
        @(negedge clk);
        st[0] = 1'b0; ai[0] = 8'h0; bi[0] = 8'h0;
        rd(0, bz, dn, res);
        check("b2b_no_idle", int'(bz), 1);
        check("b2b_hold", res, 2);
        n = 0;
        while (bz && n < 40) begin
            n++;
            @(negedge clk);
            rd(0, bz, dn, res);
        end
        check("b2b_busy_len", n, 4);
        check("b2b_second_done", int'(dn), 1);
        check("b2b_second_sum", res, 32'hF);
        prev[0] = 32'hF;

        // reset at RUN cycle 2 aborts
        @(negedge clk);
        st[0] = 1'b1; ai[0] = 8'h6; bi[0] = 8'h7; ci[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) prev[i] = 0;
        rd(0, bz, dn, res);
        check("abort_busy", int'(bz), 0);
        check("abort_done", int'(dn), 0);
        check("abort_sum", res, 0);
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rd(0, bz, dn, res);
            if (dn || bz) dcount++;
        end
        check("abort_no_activity", dcount, 0);
        op(0, 8'h6, 8'h7, 1'b1);

        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            op(0, {4'h0, v[3:0]}, {4'h0, v[7:4]}, v[8]);
        end
        for (int i = 0; i < 8; i++) begin
            v = 9'(i);
            op(1, {7'h0, v[0]}, {7'h0, v[1]}, v[2]);
        end
        for (int i = 0; i < 12; i++) op(1, 8'($urandom), 8'($urandom), 1'($urandom));
        op(2, 8'hFF, 8'hFF, 1'b1);
        op(2, 8'hFF, 8'h00, 1'b1);
        for (int i = 0; i < 60; i++) op(2, 8'($urandom), 8'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
